// File: rtl/bottle_fill_ctrl_pkg.sv
// Shared definitions for the bottling-line sequencer: state encoding and
// the default box size.
package bottle_fill_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CONVEY = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_CAP    = 3'd3;
    localparam logic [2:0] ST_COUNT  = 3'd4;
    localparam logic [2:0] ST_LOAD   = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    localparam int DOZEN_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CONVEY = ST_CONVEY,
        FILL   = ST_FILL,
        CAP    = ST_CAP,
        COUNT  = ST_COUNT,
        LOAD   = ST_LOAD,
        FAULT  = ST_FAULT
    } state_t;

endpackage

// File: rtl/bottle_fill_ctrl_sensor_debounce.sv
// Two-flop synchronizer plus run-length debounce for one raw sensor.
// o_rise is high during the cycle whose closing edge flips the filter 0->1.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // Accept on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with the filter
    assign w_accept = (r_sync2 != r_filt) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Bring the asynchronous sensor into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Run-length counter; any agreeing sample restarts the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_filt <= r_sync2;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_filt = r_filt;
    assign o_rise = w_accept & r_sync2;

endmodule

// File: rtl/bottle_fill_ctrl.sv
// Per-bottle sequencer: conveyor, fill valve and capper control, plus the
// bottle/dozen counters and load strobe for the downstream output register.
module bottle_fill_ctrl
    import bottle_fill_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FILL_TIMEOUT    = 200,
    parameter int CAP_CYCLES      = 10,
    parameter int DOZEN           = DOZEN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       fault_clr,
    input  logic       bottle_sns,
    input  logic       level_sns,
    output logic       motor_on,
    output logic       valve_on,
    output logic       cap_act,
    output logic [7:0] count_out,
    output logic       load_en,
    output logic       dozen_pulse,
    output logic       fault
);

    localparam int TMAX = (FILL_TIMEOUT > CAP_CYCLES) ? FILL_TIMEOUT : CAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_bottle_cnt;
    logic [3:0]    r_dozen_cnt;
    logic          r_motor;
    logic          r_valve;
    logic          r_cap;
    logic          r_load;
    logic          r_dpulse;
    logic          r_fault;

    logic w_bottle_filt;
    logic w_bottle_rise;
    logic w_level_filt;
    logic w_level_rise;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bottle_db (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (bottle_sns),
        .o_filt (w_bottle_filt),
        .o_rise (w_bottle_rise)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_level_db (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (level_sns),
        .o_filt (w_level_filt),
        .o_rise (w_level_rise)
    );

    // Sequencer; each branch loads the Moore outputs of the state it enters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_bottle_cnt <= 4'd0;
            r_dozen_cnt  <= 4'd0;
            r_motor      <= 1'b0;
            r_valve      <= 1'b0;
            r_cap        <= 1'b0;
            r_load       <= 1'b0;
            r_dpulse     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_motor  <= 1'b0;
            r_valve  <= 1'b0;
            r_cap    <= 1'b0;
            r_load   <= 1'b0;
            r_dpulse <= 1'b0;
            r_fault  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_state <= CONVEY;
                        r_motor <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CONVEY: begin
                    if (w_bottle_rise) begin
                        r_state <= FILL;
                        r_valve <= 1'b1;
                        r_timer <= '0;
                    end else if (stop && !w_bottle_filt) begin
                        r_state <= IDLE;
                    end else begin
                        r_motor <= 1'b1;
                    end
                end
                FILL: begin
                    // Level is tested first so it wins over a coincident timeout
                    if (w_level_filt || w_level_rise) begin
                        r_state <= CAP;
                        r_cap   <= 1'b1;
                        r_timer <= '0;
                    end else if (r_timer == TW'(FILL_TIMEOUT - 1)) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_valve <= 1'b1;
                        r_timer <= r_timer + 1'b1;
                    end
                end
                CAP: begin
                    if (r_timer == TW'(CAP_CYCLES - 1)) begin
                        r_state <= COUNT;
                        if (r_bottle_cnt == 4'(DOZEN - 1)) begin
                            r_bottle_cnt <= 4'd0;
                            r_dozen_cnt  <= r_dozen_cnt + 4'd1;
                            r_dpulse     <= 1'b1;
                        end else begin
                            r_bottle_cnt <= r_bottle_cnt + 4'd1;
                        end
                    end else begin
                        r_cap   <= 1'b1;
                        r_timer <= r_timer + 1'b1;
                    end
                end
                COUNT: begin
                    r_state <= LOAD;
                    r_load  <= 1'b1;
                end
                LOAD: begin
                    if (start && !stop) begin
                        r_state <= CONVEY;
                        r_motor <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        r_state <= IDLE;
                    end else begin
                        r_fault <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign motor_on    = r_motor;
    assign valve_on    = r_valve;
    assign cap_act     = r_cap;
    assign load_en     = r_load;
    assign dozen_pulse = r_dpulse;
    assign fault       = r_fault;
    assign count_out   = {r_dozen_cnt, r_bottle_cnt};

endmodule
